// File: rtl/matrix_stream_pkg.sv
// Shared types and helpers for the matrix result streamer: FSM states,
// default frame header and the byte-select helper used by the shadow buffer.
package matrix_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CSUM,
    DONE
  } state_t;

  localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

  // Widest element supported by get_byte; narrower words are zero-extended.
  localparam int MAX_WORD_W = 256;
  localparam int BYTE_SEL_W = 5;

  function automatic logic [7:0] get_byte(input logic [MAX_WORD_W-1:0] word,
                                          input logic [BYTE_SEL_W-1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/matrix_shadow_buf.sv
// Snapshot register for the result matrix plus the element/byte read mux.
// The read path is combinational so the FSM sees the selected byte in-cycle.
module matrix_shadow_buf
  import matrix_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_ELEM     = 16,
  parameter int IDX_W      = 4,
  parameter int B_W        = 2
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_capture,
  input  logic [N_ELEM*DATA_WIDTH-1:0] i_matrix,
  input  logic [IDX_W-1:0]             i_elem_idx,
  input  logic [B_W-1:0]               i_byte_idx,
  output logic [7:0]                   o_byte
);

  localparam int BYTES = DATA_WIDTH / 8;

  logic [N_ELEM*DATA_WIDTH-1:0] shadow_q;
  logic [N_ELEM*DATA_WIDTH-1:0] shadow_d;
  logic [DATA_WIDTH-1:0]        words [N_ELEM];
  logic [BYTE_SEL_W-1:0]        byte_sel;

  assign shadow_d = i_capture ? i_matrix : shadow_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_words
    assign words[gi] = shadow_q[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Byte counter runs 0..BYTES-1 but words leave MSB first.
  always_comb begin
    byte_sel = BYTE_SEL_W'(BYTES - 1) - BYTE_SEL_W'(i_byte_idx);
    o_byte   = get_byte(MAX_WORD_W'(words[i_elem_idx]), byte_sel);
  end

endmodule

// File: rtl/matrix_result_streamer.sv
// Captures the multiplier result matrix on i_start and streams it as a byte
// frame (header, row-major MSB-first elements, optional XOR checksum).
module matrix_result_streamer
  import matrix_stream_pkg::*;
#(
  parameter int         DATA_WIDTH      = 32,
  parameter int         N_ROWS          = 4,
  parameter int         N_COLS          = 4,
  parameter logic [7:0] HEADER_BYTE     = HEADER_BYTE_DEFAULT,
  parameter bit         APPEND_CHECKSUM = 1'b1,
  localparam int        N_ELEM          = N_ROWS * N_COLS,
  localparam int        IDX_W           = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic [N_ELEM*DATA_WIDTH-1:0] i_matrix,
  output logic [7:0]                   o_tx_data,
  output logic                         o_tx_valid,
  input  logic                         i_tx_ready,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [IDX_W-1:0]             o_elem_idx
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int B_W   = (BYTES > 1) ? $clog2(BYTES) : 1;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] elem_q, elem_d;
  logic [B_W-1:0]   byte_q, byte_d;
  logic [7:0]       csum_q, csum_d;
  logic             capture;
  logic [7:0]       shadow_byte;

  matrix_shadow_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_ELEM     (N_ELEM),
    .IDX_W      (IDX_W),
    .B_W        (B_W)
  ) u_shadow (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_capture  (capture),
    .i_matrix   (i_matrix),
    .i_elem_idx (elem_q),
    .i_byte_idx (byte_q),
    .o_byte     (shadow_byte)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      elem_q  <= '0;
      byte_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      byte_q  <= byte_d;
      csum_q  <= csum_d;
    end
  end

  // Outputs are decoded from the registered state, so valid/data stay
  // stable across stalls and drop to zero as soon as reset asserts.
  always_comb begin
    state_d    = state_q;
    elem_d     = elem_q;
    byte_d     = byte_q;
    csum_d     = csum_q;
    capture    = 1'b0;
    o_tx_valid = 1'b0;
    o_tx_data  = 8'h00;
    o_done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          capture = 1'b1;
          elem_d  = '0;
          byte_d  = '0;
          csum_d  = '0;
          state_d = HDR;
        end
      end
      HDR: begin
        o_tx_valid = 1'b1;
        o_tx_data  = HEADER_BYTE;
        if (i_tx_ready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        o_tx_valid = 1'b1;
        o_tx_data  = shadow_byte;
        if (i_tx_ready) begin
          csum_d = csum_q ^ shadow_byte;
          if (byte_q == B_W'(BYTES - 1)) begin
            byte_d = '0;
            if (elem_q == IDX_W'(N_ELEM - 1)) begin
              state_d = APPEND_CHECKSUM ? CSUM : DONE;
            end else begin
              elem_d = elem_q + 1'b1;
            end
          end else begin
            byte_d = byte_q + 1'b1;
          end
        end
      end
      CSUM: begin
        o_tx_valid = 1'b1;
        o_tx_data  = csum_q;
        if (i_tx_ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_busy     = (state_q != IDLE);
  assign o_elem_idx = elem_q;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Scoreboard bench: stimulus pushes the expected frame bytes, a negedge
// monitor pops and compares every accepted byte and checks stall stability.
module tb_matrix_result_streamer;

  localparam int NE = 16;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, start_nc, ready;
  logic [NE*DW-1:0] matrix, matrix_nc;

  logic [7:0] tx_data0, tx_data1;
  logic       tx_valid0, tx_valid1, busy0, busy1, done0, done1;
  logic [3:0] idx0, idx1;

  always #5 clk = ~clk;

  matrix_result_streamer dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_matrix   (matrix),
    .o_tx_data  (tx_data0),
    .o_tx_valid (tx_valid0),
    .i_tx_ready (ready),
    .o_busy     (busy0),
    .o_done     (done0),
    .o_elem_idx (idx0)
  );

  matrix_result_streamer #(.APPEND_CHECKSUM(1'b0)) dut_nc (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_start    (start_nc),
    .i_matrix   (matrix_nc),
    .o_tx_data  (tx_data1),
    .o_tx_valid (tx_valid1),
    .i_tx_ready (ready),
    .o_busy     (busy1),
    .o_done     (done1),
    .o_elem_idx (idx1)
  );

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  int         acc_cnt = 0;
  int         exp_len = 0;
  bit         sel = 1'b0;

  logic [7:0] m_data;
  logic       m_valid, m_done, m_busy;
  logic [3:0] m_idx;
  assign m_data  = sel ? tx_data1  : tx_data0;
  assign m_valid = sel ? tx_valid1 : tx_valid0;
  assign m_done  = sel ? done1     : done0;
  assign m_busy  = sel ? busy1     : busy0;
  assign m_idx   = sel ? idx1      : idx0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_frame(input logic [NE*DW-1:0] m, input bit with_csum,
                            input logic [7:0] csum_hand);
    exp_q.push_back(8'hA5);
    for (int e = 0; e < NE; e++) begin
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(m[e*DW + b*8 +: 8]);
      end
    end
    if (with_csum) exp_q.push_back(csum_hand);
    exp_len = exp_q.size();
  endtask

  // Monitor: byte is accepted at the posedge following a negedge that saw valid&ready.
  initial begin
    logic [7:0] e;
    bit         prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 32'(m_valid), 32'd1);
          chk("hold_data", 32'(m_data), 32'(prev_data));
        end
        if (m_valid && ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_byte actual=%0h required=none", m_data);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("byte%0d", acc_cnt), 32'(m_data), 32'(e));
          end
          acc_cnt++;
        end
        prev_stall = m_valid && !ready;
        prev_data  = m_data;
        if (m_done) begin
          chk("frame_len", acc_cnt, exp_len);
          chk("queue_drained", exp_q.size(), 0);
          $display("frame dut%0d: %0d bytes accepted, %0d expected", sel, acc_cnt, exp_len);
          acc_cnt = 0;
        end
      end
    end
  end

  // act: 0 none, 1 new matrix + start at byte 10, 2 async reset at byte 20.
  task automatic run_frame(input bit nc, input bit toggle, input int act, input int exp_done);
    int cyc;
    bit fired;
    cyc   = 0;
    fired = 1'b0;
    sel   = nc;
    @(posedge clk); #2;
    if (nc) start_nc = 1'b1;
    else    start    = 1'b1;
    ready = 1'b1;
    @(posedge clk); #2;
    start    = 1'b0;
    start_nc = 1'b0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (m_done) break;
      if (cyc > 400) begin
        chk("done_timeout", cyc, exp_done);
        return;
      end
      @(posedge clk); #2;
      start = 1'b0;
      if (toggle) ready = ((cyc + 1) % 2 == 1);
      if (act == 1 && !fired && acc_cnt >= 10) begin
        matrix = {NE{32'h55555555}};
        start  = 1'b1;
        fired  = 1'b1;
      end
      if (act == 2 && !fired && acc_cnt >= 20) begin
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_data", 32'(m_data), 0);
        chk("rst_busy", 32'(m_busy), 0);
        chk("rst_done", 32'(m_done), 0);
        chk("rst_idx", 32'(m_idx), 0);
        exp_q.delete();
        acc_cnt = 0;
        $display("frame dut%0d: aborted by reset", sel);
        return;
      end
    end
    chk("done_cycle", cyc, exp_done);
    @(negedge clk);
    chk("done_width", 32'(m_done), 0);
    chk("busy_after", 32'(m_busy), 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    start_nc  = 1'b0;
    ready     = 1'b0;
    matrix    = '0;
    matrix_nc = '0;
    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(tx_valid0), 0);
    chk("reset_data", 32'(tx_data0), 0);
    chk("reset_busy", 32'(busy0), 0);
    chk("reset_done", 32'(done0), 0);
    chk("reset_idx", 32'(idx0), 0);
    chk("reset_valid_nc", 32'(tx_valid1), 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Incrementing elements, ready always high.
    for (int e = 0; e < NE; e++) matrix[e*DW +: DW] = 32'(e + 1);
    push_frame(matrix, 1'b1, 8'h10);
    run_frame(1'b0, 1'b0, 0, 67);

    // Constant DEADBEEF with ready toggling: bytes accepted on odd cycles only.
    matrix = {NE{32'hDEADBEEF}};
    push_frame(matrix, 1'b1, 8'h00);
    run_frame(1'b0, 1'b1, 0, 132);

    // Start and matrix change while busy must not disturb the frame.
    for (int e = 0; e < NE; e++) matrix[e*DW +: DW] = {4{8'(e)}};
    push_frame(matrix, 1'b1, 8'h00);
    run_frame(1'b0, 1'b0, 1, 67);
    repeat (2) @(negedge clk);
    chk("ignored_start_idle", 32'(busy0), 0);

    // Abort by async reset, then a fresh frame with new data.
    matrix = {NE{32'h77777777}};
    push_frame(matrix, 1'b1, 8'h00);
    run_frame(1'b0, 1'b0, 2, 0);
    @(posedge clk); #2;
    rst    = 1'b0;
    matrix = '0;
    matrix[DW-1:0] = 32'h000000AB;
    push_frame(matrix, 1'b1, 8'hAB);
    run_frame(1'b0, 1'b0, 0, 67);

    // No checksum: 65 bytes, done one cycle earlier.
    matrix_nc = {NE{32'hFFFFFFFF}};
    push_frame(matrix_nc, 1'b0, 8'h00);
    run_frame(1'b1, 1'b0, 0, 66);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
